// File: rtl/dispatch_packet_arbiter.sv
// Round-robin arbiter with starvation escalation that shares one execute port among
// several packetised requesters; a grant is held from sop until eop so transactions never interleave.
module dispatch_packet_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 64,
    parameter int STARVE_LIMIT = 15,
    parameter int REQ_W        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [REQ_W-1:0]          out_idx,
    input  logic                      out_ready,
    output logic                      locked
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   lock_idx_q, lock_idx_d;
    logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wait_cnt_q [NUM_REQS];
    logic [CNT_W-1:0]   wait_cnt_d [NUM_REQS];
    logic               out_valid_q, out_valid_d;
    logic [DATAW-1:0]   out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic [REQ_W-1:0]   out_idx_q, out_idx_d;

    logic               can_load;
    logic               win_vld, starve_vld, rr_vld;
    logic [REQ_W-1:0]   starve_idx, rr_idx, win_idx, cand_idx;
    logic               cand_en, fire;
    logic [DATAW-1:0]   g_data;
    logic               g_sop, g_eop;
    int                 scan;

    function automatic logic [REQ_W-1:0] next_ptr(input logic [REQ_W-1:0] idx);
        return REQ_W'((int'(idx) + 1) % NUM_REQS);
    endfunction

    // Winner selection: starved requesters first (lowest index), else rotating scan from rr_ptr.
    always_comb begin
        starve_vld = 1'b0;
        starve_idx = '0;
        rr_vld     = 1'b0;
        rr_idx     = '0;
        scan       = 0;
        if (STARVE_LIMIT != 0) begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (req_valid[i] && wait_cnt_q[i] == CNT_W'(STARVE_LIMIT)) begin
                    starve_vld = 1'b1;
                    starve_idx = REQ_W'(i);
                end
            end
        end
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            scan = (int'(rr_ptr_q) + k) % NUM_REQS;
            if (req_valid[scan]) begin
                rr_vld = 1'b1;
                rr_idx = REQ_W'(scan);
            end
        end
        win_vld = starve_vld | rr_vld;
        win_idx = starve_vld ? starve_idx : rr_idx;
    end

    always_comb begin
        can_load = ~out_valid_q | out_ready;
        cand_idx = (state_q == LOCKED) ? lock_idx_q : win_idx;
        cand_en  = (state_q == LOCKED) | win_vld;
        req_ready = '0;
        if (cand_en && can_load) req_ready[cand_idx] = 1'b1;
        fire   = |(req_valid & req_ready);
        g_data = req_data[cand_idx*DATAW +: DATAW];
        g_sop  = req_sop[cand_idx];
        g_eop  = req_eop[cand_idx];

        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (fire) begin
            if (g_eop) begin
                state_d  = IDLE;
                rr_ptr_d = next_ptr(cand_idx);
            end else if (state_q == IDLE) begin
                state_d    = LOCKED;
                lock_idx_d = cand_idx;
            end
        end

        for (int i = 0; i < NUM_REQS; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (req_valid[i] && req_ready[i])
                wait_cnt_d[i] = '0;
            else if (req_valid[i] && wait_cnt_q[i] != CNT_W'(STARVE_LIMIT))
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_idx_d   = out_idx_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = g_data;
            out_sop_d   = g_sop;
            out_eop_d   = g_eop;
            out_idx_d   = cand_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_idx_q   <= '0;
            for (int i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_idx_q   <= out_idx_d;
            for (int i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= wait_cnt_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_idx   = out_idx_q;
    assign locked    = (state_q == LOCKED);

    // Requester protocol checks.
    a_sop_idle: assert property (@(posedge clk) disable iff (reset)
        (fire && state_q == IDLE) |-> g_sop) else $error("first packet of a grant lacks sop");
    a_sop_locked: assert property (@(posedge clk) disable iff (reset)
        (fire && state_q == LOCKED) |-> !g_sop) else $error("sop inside a locked transaction");
    a_hold_valid: assert property (@(posedge clk) disable iff (reset)
        (state_q == LOCKED) |-> req_valid[lock_idx_q]) else $error("locked requester dropped valid");
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready)) else $error("more than one req_ready bit set");

endmodule

// File: tb/tb_dispatch_packet_arbiter.sv
// Directed bench for dispatch_packet_arbiter: per-requester packet queues drive the inputs,
// a scoreboard queue holds the hand-ordered expected output stream checked by a monitor.
module tb_dispatch_packet_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  idx;
    } pkt_t;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_sop;
    logic [3:0]   req_eop;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         out_sop;
    logic         out_eop;
    logic [1:0]   out_idx;
    logic         out_ready;
    logic         locked;

    pkt_t rq [4][$];
    pkt_t exq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dispatch_packet_arbiter #(.NUM_REQS(4), .DATAW(64), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop), .req_eop(req_eop),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_idx(out_idx), .out_ready(out_ready), .locked(locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mk(input int r, input int tag, input int k);
        return {8'(r), 8'(tag), 40'h0, 8'(k)};
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*64 +: 64] = rq[i][0].data;
                req_sop[i]          = rq[i][0].sop;
                req_eop[i]          = rq[i][0].eop;
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*64 +: 64] = '0;
                req_sop[i]          = 1'b0;
                req_eop[i]          = 1'b0;
            end
        end
    endtask

    task automatic send_txn(input int r, input int n, input int tag);
        pkt_t p;
        for (int k = 0; k < n; k++) begin
            p.data = mk(r, tag, k);
            p.sop  = (k == 0);
            p.eop  = (k == n - 1);
            p.idx  = 2'(r);
            rq[r].push_back(p);
        end
        refresh();
    endtask

    task automatic expect_txn(input int r, input int n, input int tag);
        pkt_t p;
        for (int k = 0; k < n; k++) begin
            p.data = mk(r, tag, k);
            p.sop  = (k == 0);
            p.eop  = (k == n - 1);
            p.idx  = 2'(r);
            exq.push_back(p);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) rq[i].delete();
        exq.delete();
        refresh();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, output int n);
        n = 0;
        while (exq.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(exq.size()), 64'd0);
    endtask

    // Driver: a requester's head packet leaves its queue once it has been accepted.
    initial begin
        logic [3:0] fired;
        forever begin
            @(negedge clk);
            fired = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (fired[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            refresh();
        end
    end

    // Monitor: every output transfer is matched against the head of the scoreboard.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                n_checks++;
                if (exq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got idx=%0d data=%h, required none", out_idx, out_data);
                end else begin
                    e = exq.pop_front();
                    if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop || out_idx !== e.idx) begin
                        n_fail++;
                        $display("FAIL scoreboard: got idx=%0d data=%h sop=%b eop=%b, required idx=%0d data=%h sop=%b eop=%b",
                                 out_idx, out_data, out_sop, out_eop, e.idx, e.data, e.sop, e.eop);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_sop   = '0;
        req_eop   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_req_ready", 64'(req_ready), 64'd0);
            chk("idle_locked", 64'(locked), 64'd0);
        end

        // Three-packet transaction from req0 while req1 waits
        do_reset();
        send_txn(0, 3, 2);
        send_txn(1, 1, 2);
        expect_txn(0, 3, 2);
        expect_txn(1, 1, 2);
        tick();
        chk("lock_c1", 64'(locked), 64'd1);
        chk("ready_c1", 64'(req_ready), 64'b0001);
        tick();
        chk("lock_c2", 64'(locked), 64'd1);
        tick();
        chk("lock_c3", 64'(locked), 64'd0);
        chk("ready_c3", 64'(req_ready), 64'b0010);
        tick();
        chk("lock_c4", 64'(locked), 64'd0);
        wait_drain(10, n);

        // All four requesters, single-packet transactions, round robin at full rate
        do_reset();
        for (int rd = 0; rd < 2; rd++)
            for (int r = 0; r < 4; r++) begin
                send_txn(r, 1, 16 + rd);
                expect_txn(r, 1, 16 + rd);
            end
        wait_drain(20, n);
        chk("rr_cycles", 64'(n), 64'd9);

        // Backpressure in the middle of a transaction
        do_reset();
        send_txn(0, 4, 4);
        expect_txn(0, 4, 4);
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, mk(0, 4, 1));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_locked", 64'(locked), 64'd1);
        end
        out_ready = 1'b1;
        wait_drain(10, n);

        // Starvation escalation overrides the round-robin order
        do_reset();
        send_txn(0, 6, 5);
        send_txn(2, 1, 5);
        send_txn(3, 1, 5);
        expect_txn(0, 6, 5);
        expect_txn(2, 1, 5);
        expect_txn(3, 1, 5);
        expect_txn(1, 1, 5);
        for (int c = 0; c < 5; c++) tick();
        send_txn(1, 1, 5);
        wait_drain(20, n);

        // Reset while locked with a held output
        do_reset();
        out_ready = 1'b0;
        send_txn(0, 3, 6);
        tick();
        tick();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_locked", 64'(locked), 64'd1);
        do_reset();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_locked", 64'(locked), 64'd0);
        out_ready = 1'b1;
        send_txn(1, 1, 7);
        send_txn(3, 1, 7);
        expect_txn(1, 1, 7);
        expect_txn(3, 1, 7);
        wait_drain(10, n);
        tick();
        tick();
        chk("final_locked", 64'(locked), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_packet_arbiter.md
Name: dispatch_packet_arbiter

Overview:
Shares one execute-unit input port among NUM_REQS issue-slot requesters that each send multi-packet transactions (sop/eop framed, pid-sequenced). Once a requester is granted, the arbiter holds the grant until that requester's eop packet transfers, so packets from different warps never interleave. Arbitration is round-robin with starvation escalation. The output is a one-stage registered pipeline stage. It sits between the per-slot dispatch packetisers and a single shared functional-unit execute interface.

Parameters:
NUM_REQS, 4, number of requesters (issue slots); must be >= 1
DATAW, 64, payload width per packet (excludes sop/eop)
STARVE_LIMIT, 15, wait-cycle threshold for priority escalation; 0 disables escalation
REQ_W, LOG2UP(NUM_REQS), derived index width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQS  per-requester packet valid
req_data  in  NUM_REQS*DATAW  per-requester packet payload
req_sop  in  NUM_REQS  first packet of transaction
req_eop  in  NUM_REQS  last packet of transaction
req_ready  out  NUM_REQS  per-requester accept; one-hot or zero
out_valid  out  1  registered output valid
out_data  out  DATAW  registered payload
out_sop  out  1  registered sop
out_eop  out  1  registered eop
out_idx  out  REQ_W  requester index of the output packet
out_ready  in  1  downstream accept
locked  out  1  high while a transaction is mid-flight (LOCKED state)

Behaviour:
- Reset: out_valid=0, out_data/out_sop/out_eop/out_idx=0, locked=0, state=IDLE, rr_ptr=0, all wait counters=0. A reset in mid-transaction drops the lock immediately; the partial transaction is discarded.
- can_load = ~out_valid | out_ready. Fire_i = req_valid[i] & req_ready[i].
- Winner selection is combinational and is evaluated only in IDLE:
  - If any valid requester has wait_cnt == STARVE_LIMIT (and STARVE_LIMIT != 0), the lowest-index such requester wins.
  - Otherwise the first valid requester is chosen, scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQS.
- In LOCKED, the only candidate is lock_idx. Valid from any other requester is ignored.
- req_ready[i] = (i == candidate) & can_load. This is independent of req_valid[i] only for the locked requester; in IDLE it requires req_valid[i]. At most one bit is set.
- FSM:
  - IDLE -> LOCKED on a fire with eop=0; lock_idx <= winner.
  - IDLE stays IDLE on a fire with eop=1.
  - LOCKED -> IDLE on a fire from lock_idx with eop=1.
  - Any fire with eop=1 sets rr_ptr <= (granted index + 1) mod NUM_REQS. rr_ptr is unchanged otherwise.
- Output register:
  - On fire: out_valid<=1 and payload/sop/eop/idx <= granted inputs.
  - Else if out_ready: out_valid<=0.
  - Latency is 1 cycle. Full throughput is 1 packet/cycle when out_ready stays high. A held output applies backpressure to all requesters.
- locked = (state == LOCKED). It is asserted the cycle after a non-eop fire.
- Wait counters (per requester, width LOG2UP(STARVE_LIMIT+1)):
  - Reset to 0 on that requester's fire.
  - Otherwise +1 when req_valid is high and the requester does not fire, saturating at STARVE_LIMIT.
  - Counters also advance in LOCKED for waiting requesters.
- Protocol checks (simulation assertions):
  - In IDLE, a granted packet must have sop=1.
  - In LOCKED, the requester's packet must have sop=0.
  - req_valid of the locked requester must not drop while LOCKED.
  - At most one req_ready bit is high.
- Single-packet transaction (sop=eop=1) never enters LOCKED.
- NUM_REQS==1: rr logic degenerates and out_idx=0. Behaviour is otherwise identical.
- If eop fires and, in the same cycle, a new candidate is valid: the new grant happens on the next cycle (no same-cycle re-arbitration).

Test Plan:
- Reset then idle: all req_valid=0 -> out_valid=0, req_ready=0, locked=0 for 10 cycles.
- Req0 sends 3 packets (sop,-,eop) while req1 is valid continuously with out_ready=1 -> out_idx=0,0,0 on consecutive cycles, locked=1 for 2 cycles, then req1 is granted and rr_ptr=1.
- All 4 requesters send single-packet transactions continuously -> output order 0,1,2,3,0,... with one packet per cycle.
- out_ready=0 for 5 cycles mid-transaction -> out_data is held stable, req_ready=0, no counter fires for the locked requester; the transaction resumes on out_ready=1 without loss.
- STARVE_LIMIT=3, req0 sends a 6-packet transaction while req2 and req3 wait -> after eop, req2 (lowest starved) wins over rr_ptr order, then req3.
- Reset asserted while LOCKED with out_valid=1 -> next cycle out_valid=0, locked=0, rr_ptr=0; a fresh sop from req1 is granted.
